// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared widths, reset PC and sequencer state encoding        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int unsigned DEFAULT_WORD_W   = 16;
  localparam int unsigned DEFAULT_ADDR_W   = 16;
  localparam int unsigned DEFAULT_CNT_W    = 16;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : enable-gated up counter that sticks at all-ones         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer : FETCH/EXEC/HALT sequencer owning PC, IR and retire  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned       WORD_W   = DEFAULT_WORD_W,
  parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned       CNT_W    = DEFAULT_CNT_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [WORD_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              exec_done,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              wwd,
  input  logic [WORD_W-1:0] wwd_data,
  input  logic              hlt,
  output logic [WORD_W-1:0] output_port,
  output logic [CNT_W-1:0]  num_inst,
  output logic              is_halted
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              retire;

  // Datapath inputs only matter in the single cycle an EXEC instruction retires.
  assign retire = (state_q == ST_EXEC) && exec_done;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    out_d   = out_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (wwd) begin
            out_d = wwd_data;
          end
          if (hlt) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc[ADDR_W-1:0];
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      out_q   <= out_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .count (num_inst)
  );

  assign imem_req    = (state_q == ST_FETCH);
  assign inst_valid  = (state_q == ST_EXEC);
  assign is_halted   = (state_q == ST_HALT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign output_port = out_q;

endmodule
`default_nettype wire
